// File: rtl/reg_arb_pkg.sv
// Shared types for the round-robin register write arbiter.
// State encoding and index-width helper.
package reg_arb_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GRANT = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_GRANT = ST_GRANT,
    S_WRITE = ST_WRITE,
    S_CHECK = ST_CHECK,
    S_DONE  = ST_DONE
  } state_t;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester / shared-register bus of the write arbiter.
// master = requesters + register, slave = arbiter.
interface reg_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        done;
  logic                      err;
  logic                      reg_en;
  logic [DATA_W-1:0]         reg_d;
  logic [DATA_W-1:0]         reg_q;
  logic                      busy;

  modport master (
    output req, wdata, reg_q,
    input  grant, done, err, reg_en, reg_d, busy
  );

  modport slave (
    input  req, wdata, reg_q,
    output grant, done, err, reg_en, reg_d, busy
  );
endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first request
// above the last-grant pointer, wrapping.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_lp,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IW-1:0]      o_idx
);

  always_comb begin
    logic found;
    int   c;
    o_onehot = '0;
    o_idx    = '0;
    found    = 1'b0;
    c        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = (int'(i_lp) + k) % NUM_REQ;
      if (!found && i_req[c]) begin
        found       = 1'b1;
        o_onehot[c] = 1'b1;
        o_idx       = IW'(c);
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter owning the enable of one shared register.
// Define REG_ARB_VERIFY_EN to add Q readback with retries.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic                clock,
  input  logic                reset,
  reg_write_arbiter_if.slave  bus
);

  localparam int IW = idx_w(NUM_REQ);

  state_t              r_state;
  logic [IW-1:0]       r_lp;
  logic [DATA_W-1:0]   r_data;
  logic [NUM_REQ-1:0]  r_grant;
  logic [NUM_REQ-1:0]  r_done;
  logic                r_err;
  logic                r_reg_en;
  logic [DATA_W-1:0]   r_reg_d;
  logic                r_busy;

  logic [NUM_REQ-1:0]  w_onehot;
  logic [IW-1:0]       w_idx;
  logic [DATA_W-1:0]   w_slice;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .i_req    (bus.req),
    .i_lp     (r_lp),
    .o_onehot (w_onehot),
    .o_idx    (w_idx)
  );

  assign w_slice = bus.wdata[int'(w_idx)*DATA_W +: DATA_W];

`ifdef REG_ARB_VERIFY_EN
  localparam int RW = idx_w(MAX_RETRY + 1);
  logic [RW-1:0] r_retry;
`else
  logic w_unused_q;
  assign w_unused_q = ^{bus.reg_q, (MAX_RETRY != 0)};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_lp     <= IW'(NUM_REQ - 1);
      r_data   <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_err    <= 1'b0;
      r_reg_en <= 1'b0;
      r_reg_d  <= '0;
      r_busy   <= 1'b0;
`ifdef REG_ARB_VERIFY_EN
      r_retry  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|bus.req) begin
            r_lp    <= w_idx;
            r_data  <= w_slice;
            r_grant <= w_onehot;
            r_reg_d <= w_slice;
            r_busy  <= 1'b1;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_reg_en <= 1'b1;
          r_state  <= S_WRITE;
        end
        S_WRITE: begin
          r_reg_en <= 1'b0;
`ifdef REG_ARB_VERIFY_EN
          r_state  <= S_CHECK;
`else
          r_done   <= r_grant;
          r_state  <= S_DONE;
`endif
        end
`ifdef REG_ARB_VERIFY_EN
        S_CHECK: begin
          if (bus.reg_q == r_data) begin
            r_done  <= r_grant;
            r_state <= S_DONE;
          end else if (r_retry < RW'(MAX_RETRY)) begin
            r_retry  <= r_retry + 1'b1;
            r_reg_en <= 1'b1;
            r_state  <= S_WRITE;
          end else begin
            r_done  <= r_grant;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          r_done  <= '0;
          r_err   <= 1'b0;
          r_grant <= '0;
          r_busy  <= 1'b0;
`ifdef REG_ARB_VERIFY_EN
          r_retry <= '0;
`endif
          r_state <= S_IDLE;
        end
        default: begin
          r_reg_en <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.grant  = r_grant;
  assign bus.done   = r_done;
  assign bus.err    = r_err;
  assign bus.reg_en = r_reg_en;
  assign bus.reg_d  = r_reg_d;
  assign bus.busy   = r_busy;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a
// behavioural enable-gated register on Q.
module tb_reg_write_arbiter;

  logic clock;
  logic reset;
  logic stuck;
  logic [7:0] q_mdl;
  int n_chk;
  int n_fail;

  reg_write_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

  reg_write_arbiter #(
    .NUM_REQ   (4),
    .DATA_W    (8),
    .MAX_RETRY (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial q_mdl = 8'h00;
  always @(posedge clock)
    if (bus.reg_en) q_mdl <= bus.reg_d;

  assign bus.reg_q = stuck ? 8'h00 : q_mdl;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int pulses;
    int dcyc;
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    stuck  = 1'b0;
    bus.req   = '0;
    bus.wdata = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_en", 32'(bus.reg_en), 0);
    chk("rst_d", 32'(bus.reg_d), 0);
    chk("rst_busy", 32'(bus.busy), 0);

    // single write from requester 2
    bus.wdata[2*8 +: 8] = 8'hA5;
    bus.req = 4'b0100;
    tick();
    chk("sw_grant", 32'(bus.grant), 32'b0100);
    chk("sw_busy", 32'(bus.busy), 1);
    chk("sw_en_c1", 32'(bus.reg_en), 0);
    tick();
    chk("sw_en_c2", 32'(bus.reg_en), 1);
    chk("sw_d_c2", 32'(bus.reg_d), 32'hA5);
`ifndef REG_ARB_VERIFY_EN
    tick();
    chk("sw_done", 32'(bus.done), 32'b0100);
    chk("sw_en_c3", 32'(bus.reg_en), 0);
    chk("sw_err", 32'(bus.err), 0);
    chk("sw_q", 32'(q_mdl), 32'hA5);
    bus.req = '0;
    tick();
    chk("sw_idle_busy", 32'(bus.busy), 0);
    chk("sw_idle_done", 32'(bus.done), 0);
    chk("sw_idle_grant", 32'(bus.grant), 0);
    chk("sw_hold_d", 32'(bus.reg_d), 32'hA5);

    // all four requesting continuously
    do_reset();
    bus.wdata = 32'h13121110;
    bus.req = 4'b1111;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k % 4 == 1)
        chk("cont_grant", 32'(bus.grant),
            32'(1 << ((k / 4) % 4)));
      if (k % 4 == 2)
        chk("cont_d", 32'(bus.reg_d),
            32'h10 + 32'((k / 4) % 4));
      if (k == 17) bus.req = '0;
    end
    tick();
    tick();
    chk("cont_idle", 32'(bus.busy), 0);

    // wdata change after grant must not leak
    bus.wdata[0 +: 8] = 8'h5A;
    bus.req = 4'b0001;
    tick();
    chk("dc_grant", 32'(bus.grant), 32'b0001);
    bus.wdata[0 +: 8] = 8'hFF;
    tick();
    chk("dc_d", 32'(bus.reg_d), 32'h5A);
    tick();
    chk("dc_done", 32'(bus.done), 32'b0001);
    chk("dc_q", 32'(q_mdl), 32'h5A);
    bus.req = '0;
    tick();

    // owner drops req before done
    bus.wdata[3*8 +: 8] = 8'h77;
    bus.req = 4'b1000;
    tick();
    chk("drop_grant", 32'(bus.grant), 32'b1000);
    bus.req = '0;
    tick();
    tick();
    chk("drop_done", 32'(bus.done), 32'b1000);
    chk("drop_q", 32'(q_mdl), 32'h77);
    tick();
`else
    bus.req = '0;
    tick();
    chk("v_check_done", 32'(bus.done), 0);
    chk("v_check_en", 32'(bus.reg_en), 0);
    tick();
    chk("v_done", 32'(bus.done), 32'b0100);
    chk("v_err", 32'(bus.err), 0);
    tick();

    // stuck register: 3 writes then err
    stuck = 1'b1;
    bus.wdata[1*8 +: 8] = 8'h3C;
    bus.req = 4'b0010;
    pulses = 0;
    dcyc = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) bus.req = '0;
      if (bus.reg_en) pulses++;
      if (dcyc == 0 && bus.done != 0) begin
        dcyc = k;
        chk("stk_done", 32'(bus.done), 32'b0010);
        chk("stk_err", 32'(bus.err), 1);
      end
    end
    chk("stk_pulses", 32'(pulses), 3);
    chk("stk_dcyc", 32'(dcyc), 8);
    stuck = 1'b0;
`endif

    // async reset in the middle of WRITE
    do_reset();
    bus.wdata[1*8 +: 8] = 8'h66;
    bus.req = 4'b0010;
    tick();
    tick();
    chk("mr_en_pre", 32'(bus.reg_en), 1);
    reset = 1'b1;
    #1;
    chk("mr_en", 32'(bus.reg_en), 0);
    chk("mr_grant", 32'(bus.grant), 0);
    chk("mr_busy", 32'(bus.busy), 0);
    chk("mr_d", 32'(bus.reg_d), 0);
    bus.req = '0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mr_no_done", 32'(bus.done), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write arbiter that shares one enable-gated data register (D, enable and clock in; Q out) among `NUM_REQ` requesters. It accepts write requests, grants one requester at a time, and drives the register's `en`/`new_D` inputs for exactly one clock per write. In the optional verify build it also reads `Q` back and retries on mismatch. It sits between the requesting logic and the shared register, and is the only block allowed to drive that register's enable.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: register data width.
- `MAX_RETRY`, 2: write retries after a readback mismatch; used only with verify compiled in.

- `clock`, in, 1: single clock; all state is updated on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req`, in, `NUM_REQ`: per-requester write request, level-held until `done`.
- `wdata`, in, `NUM_REQ*DATA_W`: requester i's data is slice `[i*DATA_W +: DATA_W]`.
- `grant`, out, `NUM_REQ`: one-hot owner of the current transaction.
- `done`, out, `NUM_REQ`: one-cycle, one-hot completion pulse.
- `err`, out, 1: one-cycle pulse alongside `done` when verify fails; always 0 without verify.
- `reg_en`, out, 1: drives the register enable.
- `reg_d`, out, `DATA_W`: drives the register D input.
- `reg_q`, in, `DATA_W`: register Q readback.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- **Reset values:** `grant`=0, `done`=0, `err`=0, `reg_en`=0, `reg_d`=0, `busy`=0. State is IDLE, retry count is 0, and the last-grant pointer `lp` = `NUM_REQ-1`, so requester 0 wins first.
- **IDLE**
  - If `req` != 0, pick the first set bit searching from `lp+1` upward, wrapping modulo `NUM_REQ`.
  - Latch the winner index and its `wdata` slice, set `lp` to the winner, go to GRANT.
- **GRANT:** `grant` = one-hot winner; `reg_d` = latched data. Go to WRITE.
- **WRITE:** `reg_en`=1 for this cycle only; `reg_d` is held. Go to CHECK if verify is built in, otherwise DONE.
- **CHECK (verify only)**
  - If `reg_q` == latched data, go to DONE.
  - Else if retry count < `MAX_RETRY`, increment the count and go to WRITE.
  - Else go to DONE with the error flag set.
- **DONE**
  - `done[winner]`=1, and `err` = error flag.
  - Clear `grant`, the retry count and the error flag on exit; go to IDLE.
- **Data capture:** the latched data is captured only in IDLE. `wdata` or `req` changes after the grant do not affect the transaction in flight.
- **Dropped request:** if the owner drops `req` before `done`, the write still completes and `done` still pulses.
- **Request held past done:** a requester still asserting `req` in the cycle after `done` re-competes. Round robin places it last.
- **Simultaneous requests:** only one winner per arbitration; the others wait with no loss.
- **Reg_d between transactions:** `reg_d` holds its last value while IDLE, and `reg_en` is 0 in every state except WRITE.

## Timing
- **Write path:** `req` sampled in IDLE at cycle 0 gives `grant` in cycle 1, `reg_en` in cycle 2, and the register loads at the end of cycle 2.
- **Without verify:** `done` in cycle 3, IDLE in cycle 4. One write per 4 cycles under continuous load.
- **With verify:** CHECK in cycle 3 (`reg_q` is valid after the load edge) and `done` in cycle 4. Each retry adds 2 cycles; worst case is 4 + 2·`MAX_RETRY` + 1 cycles.
- **Reset mid-operation:** `reset` asserted in any state forces every output to its reset value asynchronously (`reg_en` drops within the same cycle). The transaction in flight is discarded with no `done`.

## Configuration
- `REG_ARB_VERIFY_EN` defined: CHECK state, retry counter, `MAX_RETRY` and the `err` logic are compiled in; `reg_q` is used.
- Not defined: WRITE goes directly to DONE, `err` is tied to 0, `reg_q` is ignored, and `MAX_RETRY` has no effect.

## Structure
- **Shared package `reg_arb_pkg`:**
  - State encoding localparams: IDLE=0, GRANT=1, WRITE=2, CHECK=3, DONE=4, in a 3-bit state register.
  - Width helper for the index/pointer width, `$clog2(NUM_REQ)`.
- **Sub-module `rr_pick`:** combinational round-robin picker. Inputs are `req` and `lp`; outputs are a one-hot winner and its index. It is instantiated once, and the top block holds the FSM and datapath latches.

## Test plan
- **Reset:** hold `reset`=1 mid-WRITE -> `reg_en` drops in the same cycle; all outputs are 0 and no `done` pulses.
- **Single write:** `req`=4'b0100, slice 2 = 8'hA5 -> `grant`=4'b0100 in cycle 1; `reg_en`=1 with `reg_d`=8'hA5 in cycle 2; `done`=4'b0100 in cycle 3.
- **Contention:** `req`=4'b1111 held continuously after reset -> grant order 0,1,2,3,0, with grants spaced 4 cycles apart.
- **Data change after grant:** `wdata` changes after `grant` rises -> the register still receives the value latched in IDLE.
- **Verify, clean:** with `REG_ARB_VERIFY_EN` and a register model that works -> `done` in cycle 4, `err`=0.
- **Verify, stuck register:** with `REG_ARB_VERIFY_EN`, Q stuck at 8'h00, data 8'h3C, `MAX_RETRY`=2 -> 3 `reg_en` pulses, then `done` with `err`=1 in the same cycle.
